cla_pipe_adder: RTL and testbench
=================================

// Module: cla_pipe_adder
// PURPOSE
//  Parametrised two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
//  Widens the 4-bit ripple-lookahead cell to WIDTH bits using GROUP-bit lookahead groups and a
//  second-level group lookahead.
//  Serves as the arithmetic core for datapath blocks that need a registered add/sub at
//  streaming rate.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; must be a multiple of GROUP (elaboration error otherwise)
//  GROUP   4  bits per lookahead group; group count NG = WIDTH/GROUP
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add mode only)
//  sub        in   1      1: compute a - b; 0: compute a + b + cin
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  s          out  WIDTH  sum/difference
//  cout       out  1      carry-out of MSB (sub mode: 1 = no borrow)
//  ovf        out  1      signed overflow; present only with CLA_OVF_EN
// BEHAVIOUR
//  - Interface: one clock (clk); reset synchronous, active-high (rst).
//  - Transfer: a beat moves on a port when valid & ready are both high at a rising edge.
//  - Operand conditioning:
//    - sub=1: bb = ~b, c0 = 1 (cin ignored).
//    - sub=0: bb = b, c0 = cin.
//  - Stage 1 (registered on accept):
//    - per-bit p = a^bb, g = a&bb;
//    - per-group GP = &p, GG = lookahead over the group's g/p;
//    - c0; valid flag v1.
//  - Stage 2 (registered):
//    - group carries Cg[k+1] = GG[k] | GP[k]&Cg[k], with Cg[0] = c0, flattened (no ripple across groups);
//    - in-group bit carries by lookahead from Cg[k];
//    - s = p ^ carries; cout = Cg[NG]; valid flag v2 = out_valid.
//  - Arithmetic: modulo 2^WIDTH; result == (a + bb + c0) truncated, cout = bit WIDTH.
//  - Latency: 2 cycles from input accept to out_valid when out_ready is held high.
//    - Throughput 1 beat/cycle.
//  - Flow control:
//    - adv2 = ~v2 | out_ready;
//    - adv1 = ~v1 | adv2;
//    - in_ready = adv1 (combinational from out_ready; no skid buffer).
//  - Stall: with out_ready low and both stages full, in_ready = 0.
//    - s/cout/out_valid are held stable until accepted.
//  - Stage 2 with adv2 & ~v1 loads v2 = 0.
//    - Data registers may hold stale values while out_valid = 0.
//  - Reset: v1 = v2 = 0, s = 0, cout = 0, ovf = 0.
//    - in_ready = 1 in the first cycle after reset.
//    - rst mid-stream discards all in-flight beats; no output is produced for them.
//  - Simultaneous events: accept at input and emit at output in the same cycle is legal at full rate.
// CONFIGURATION
//  CLA_OVF_EN defined:
//    - stage 1 additionally registers a[WIDTH-1] and bb[WIDTH-1];
//    - stage 2 drives ovf = (a_msb == bb_msb) & (s[WIDTH-1] != a_msb);
//    - ovf is registered with s and held under stall.
//  CLA_OVF_EN undefined: no ovf port, no extra registers; all other behaviour identical.
// TESTING (WIDTH=16, GROUP=4 unless noted)
//  1. Add wraparound: a=FFFF, b=0001, cin=0, sub=0, out_ready=1
//     -> 2 cycles later: out_valid=1, s=0000, cout=1.
//  2. Subtract: a=0005, b=0007, sub=1, cin=1 (ignored) -> s=FFFE, cout=0.
//     Then a=0007, b=0005 -> s=0002, cout=1.
//  3. Backpressure: stream beats 1..6 (a=n, b=n), out_ready=0 for cycles 2-5
//     -> in_ready=0 once two beats are held;
//     -> outputs 2,4,6,8,10,12 appear in order, no loss or duplication; s stable while stalled.
//  4. Reset mid-op: accept two beats, assert rst one cycle
//     -> out_valid=0, s=0, cout=0 next cycle; neither beat ever emerges; in_ready=1.
//  5. With CLA_OVF_EN:
//     - 7FFF+0001 -> s=8000, ovf=1;
//     - 8000-0001 -> s=7FFF, ovf=1;
//     - 0003+0004 -> ovf=0.
//  6. Random: 10k beats with random out_ready, plus WIDTH=32 GROUP=8 build
//     -> every {cout,s} == a+bb+c0 reference, in order.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder/subtractor
// with valid/ready flow control.
// Stage 1 conditions the operands and registers per-bit propagate/generate
// and per-group lookahead terms. Stage 2 resolves the group carries with a
// flattened second-level lookahead, then forms the bit carries and the sum.
// Optional feature: define CLA_OVF_EN to add the registered signed-overflow
// output ovf.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0) begin : g_width_check
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end

  // Carry into bit position n of a group, as a sum of products over the
  // lower n generate/propagate bits and the group carry-in (no rippling).
  function automatic logic la_carry(input logic [GROUP-1:0] g,
                                    input logic [GROUP-1:0] p,
                                    input logic             ci,
                                    input int               n);
    logic c;
    logic t;
    c = ci;
    for (int m = 0; m < GROUP; m++) begin
      if (m < n) c = c & p[m];
    end
    for (int j = 0; j < GROUP; j++) begin
      if (j < n) begin
        t = g[j];
        for (int m = 0; m < GROUP; m++) begin
          if (m > j && m < n) t = t & p[m];
        end
        c = c | t;
      end
    end
    return c;
  endfunction

  // Handshake state
  logic v1, v2;
  logic adv1, adv2;

  // Stage 1 combinational terms
  logic [WIDTH-1:0] bb, p_d, g_d;
  logic             c0_d;
  logic [NG-1:0]    gp_d, gg_d;

  // Stage 1 registers
  logic [WIDTH-1:0] p_q, g_q;
  logic             c0_q;
  logic [NG-1:0]    gp_q, gg_q;
`ifdef CLA_OVF_EN
  logic             a_msb_q, bb_msb_q;
`endif

  // Stage 2 combinational terms
  logic [NG:0]      cg;
  logic [WIDTH-1:0] carry, sum_c;

  // A stage advances when its output slot is empty or being drained.
  assign adv2      = ~v2 | out_ready;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  // Operand conditioning and per-bit / per-group propagate-generate terms.
  always_comb begin
    // NOTE: every variable gets a value before any branch or loop, so no
    // path through the block leaves one unassigned and no latch is inferred.
    bb   = sub ? ~b : b;
    c0_d = sub ? 1'b1 : cin;
    p_d  = a ^ bb;
    g_d  = a & bb;
    gp_d = '0;
    gg_d = '0;
    for (int k = 0; k < NG; k++) begin
      gp_d[k] = &p_d[k*GROUP +: GROUP];
      gg_d[k] = la_carry(g_d[k*GROUP +: GROUP], p_d[k*GROUP +: GROUP], 1'b0, GROUP);
    end
  end

  // Stage 1 valid flag: reloads whenever the stage advances.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples its inputs from before the edge, regardless of block order.
    if (rst) v1 <= 1'b0;
    else if (adv1) v1 <= in_valid;
  end

  // Stage 1 datapath: captured only on an accepted beat.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are deliberately not reset; they are only
    // observed while the matching valid flag is set, which reset clears.
    if (adv1 && in_valid) begin
      p_q  <= p_d;
      g_q  <= g_d;
      c0_q <= c0_d;
      gp_q <= gp_d;
      gg_q <= gg_d;
`ifdef CLA_OVF_EN
      a_msb_q  <= a[WIDTH-1];
      bb_msb_q <= bb[WIDTH-1];
`endif
    end
  end

  // Flattened group carries, then in-group bit carries and the sum.
  always_comb begin
    logic t;
    logic u;
    t     = 1'b0;
    u     = 1'b0;
    cg    = '0;
    carry = '0;
    cg[0] = c0_q;
    for (int k = 0; k < NG; k++) begin
      t = c0_q;
      for (int m = 0; m <= k; m++) t = t & gp_q[m];
      for (int j = 0; j <= k; j++) begin
        u = gg_q[j];
        for (int m = j + 1; m <= k; m++) u = u & gp_q[m];
        t = t | u;
      end
      cg[k+1] = t;
    end
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        carry[k*GROUP+i] = la_carry(g_q[k*GROUP +: GROUP], p_q[k*GROUP +: GROUP], cg[k], i);
      end
    end
    sum_c = p_q ^ carry;
  end

  // Stage 2 result registers: held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2   <= 1'b0;
      s    <= '0;
      cout <= 1'b0;
`ifdef CLA_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s    <= sum_c;
        cout <= cg[NG];
`ifdef CLA_OVF_EN
        ovf  <= (a_msb_q == bb_msb_q) & (sum_c[WIDTH-1] != a_msb_q);
`endif
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed and randomized bench for cla_pipe_adder.
// A 16/4 instance is the main target; a 32/8 instance shares flow control
// and is checked during the random run. ovf is checked when CLA_OVF_EN is set.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, in_ready32, cin, sub;
  logic        out_valid, out_valid32, out_ready, cout, cout32;
  logic [15:0] a, b, s;
  logic [31:0] a32, b32, s32;
`ifdef CLA_OVF_EN
  logic        ovf, ovf32;
`endif

  int total = 0;
  int bad   = 0;

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout)
`ifdef CLA_OVF_EN
    , .ovf(ovf)
`endif
  );

  cla_pipe_adder #(.WIDTH(32), .GROUP(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin), .sub(sub),
    .out_valid(out_valid32), .out_ready(out_ready), .s(s32), .cout(cout32)
`ifdef CLA_OVF_EN
    , .ovf(ovf32)
`endif
  );

  // Reference: plain arithmetic, subtraction as a - b with no-borrow flag.
  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    if (sb) return {x >= y, x - y};
    return {1'b0, x} + {1'b0, y} + {16'd0, ci};
  endfunction

  function automatic logic [32:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic sb);
    if (sb) return {x >= y, x - y};
    return {1'b0, x} + {1'b0, y} + {32'd0, ci};
  endfunction

  function automatic logic ref_ovf16(input logic [15:0] x, input logic [15:0] y,
                                     input logic ci, input logic sb);
    int sx, sy, r;
    sx = $signed(x);
    sy = $signed(y);
    r  = sb ? sx - sy : sx + sy + int'(ci);
    return (r > 32767) || (r < -32768);
  endfunction

  function automatic logic ref_ovf32(input logic [31:0] x, input logic [31:0] y,
                                     input logic ci, input logic sb);
    longint sx, sy, r;
    sx = $signed(x);
    sy = $signed(y);
    r  = sb ? sx - sy : sx + sy + longint'(ci);
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; a32 = '0; b32 = '0; cin = 1'b0; sub = 1'b0;
    tick; tick;
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    total++; if (s !== 16'h0000) begin bad++; $display("FAIL reset_s: got %h exp 0000", s); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b exp 0", cout); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
`ifdef CLA_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b exp 0", ovf); end
`endif
  endtask

  // One beat through an idle pipe with out_ready high; checks 2-cycle latency.
  task automatic send_one(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                          input logic tsub, input logic [15:0] es, input logic ec,
                          input logic eo, input string name);
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready: got %b exp 1", name, in_ready); end
    tick;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_early: out_valid %b exp 0", name, out_valid); end
    tick;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_valid: got %b exp 1", name, out_valid); end
    total++; if (s !== es) begin bad++; $display("FAIL %s_s: got %h exp %h (exp ovf %b)", name, s, es, eo); end
    total++; if (cout !== ec) begin bad++; $display("FAIL %s_cout: got %b exp %b", name, cout, ec); end
`ifdef CLA_OVF_EN
    total++; if (ovf !== eo) begin bad++; $display("FAIL %s_ovf: got %b exp %b", name, ovf, eo); end
`endif
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_drain: out_valid %b exp 0", name, out_valid); end
  endtask

  task automatic test_add_wrap;
    send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
    send_one(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "add_cin");
  endtask

  task automatic test_sub;
    send_one(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    send_one(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_plain");
  endtask

`ifdef CLA_OVF_EN
  task automatic test_ovf;
    send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add");
    send_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf_sub");
    send_one(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, "ovf_none");
  endtask
`endif

  task automatic test_backpressure;
    logic [16:0] q[$];
    logic [16:0] e;
    logic [15:0] held_s;
    logic        hold, saw_stall;
    int          nxt, got;
    nxt = 1; got = 0; hold = 1'b0; saw_stall = 1'b0; held_s = '0;
    sub = 1'b0; cin = 1'b0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      in_valid  = (nxt <= 6);
      a         = 16'(nxt);
      b         = 16'(nxt);
      out_ready = !(c >= 2 && c <= 5);
      #1;
      if (hold) begin
        total++;
        if (s !== held_s) begin bad++; $display("FAIL bp_hold: s %h changed from %h", s, held_s); end
      end
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        got++;
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL bp_extra: got %h with nothing expected", s);
        end else begin
          e = q.pop_front();
          if ({cout, s} !== e) begin bad++; $display("FAIL bp_data: got %h exp %h", {cout, s}, e); end
        end
      end
      hold   = out_valid && !out_ready;
      held_s = s;
      if (in_valid && in_ready) begin
        q.push_back(17'(2 * nxt));
        nxt++;
      end
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got != 6) begin bad++; $display("FAIL bp_count: got %0d beats exp 6", got); end
    total++; if (!saw_stall) begin bad++; $display("FAIL bp_stall: in_ready never low, exp low"); end
    total++; if (q.size() != 0) begin bad++; $display("FAIL bp_left: %0d beats missing exp 0", q.size()); end
  endtask

  task automatic test_reset_midop;
    sub = 1'b0; cin = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    a = 16'h0101; b = 16'h0202;
    tick;
    a = 16'h0303; b = 16'h0404;
    tick;
    in_valid = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0; out_ready = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b exp 0", out_valid); end
    total++; if (s !== 16'h0000) begin bad++; $display("FAIL rst_mid_s: got %h exp 0000", s); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL rst_mid_cout: got %b exp 0", cout); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready: got %b exp 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_ghost: out_valid %b exp 0 (cycle %0d)", out_valid, i); end
    end
  endtask

  task automatic test_random(input int n);
    logic [16:0] q16[$];
    logic [32:0] q32[$];
    logic        qo16[$];
    logic        qo32[$];
    logic [16:0] e16;
    logic [32:0] e32;
    logic        accepted, eo;
    int          sent, got, got32, cyc;
    sent = 0; got = 0; got32 = 0; cyc = 0; accepted = 1'b0;
    rst = 1'b1; in_valid = 1'b0; tick; rst = 1'b0;
    while ((got < n || got32 < n) && cyc < n * 12) begin
      if (!in_valid || accepted) begin
        in_valid = (sent < n) && ($urandom_range(0, 3) != 0);
        a   = 16'($urandom);  b   = 16'($urandom);
        a32 = $urandom;       b32 = $urandom;
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) begin
          a = 16'hFFFF; b = 16'($urandom_range(0, 1));
          a32 = 32'hFFFF_FFFF; b32 = 32'($urandom_range(0, 1));
        end else if ($urandom_range(0, 7) == 0) begin
          b = a; b32 = a32;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      accepted = in_valid && in_ready;
      if (accepted) begin
        q16.push_back(ref16(a, b, cin, sub));
        qo16.push_back(ref_ovf16(a, b, cin, sub));
        sent++;
      end
      if (in_valid && in_ready32) begin
        q32.push_back(ref32(a32, b32, cin, sub));
        qo32.push_back(ref_ovf32(a32, b32, cin, sub));
      end
      if (out_valid && out_ready) begin
        got++;
        total++;
        if (q16.size() == 0) begin
          bad++; $display("FAIL rnd16_extra: got %h with nothing expected", {cout, s});
        end else begin
          e16 = q16.pop_front();
          eo  = qo16.pop_front();
          if ({cout, s} !== e16) begin bad++; $display("FAIL rnd16_data: got %h exp %h", {cout, s}, e16); end
`ifdef CLA_OVF_EN
          total++; if (ovf !== eo) begin bad++; $display("FAIL rnd16_ovf: got %b exp %b", ovf, eo); end
`endif
        end
      end
      if (out_valid32 && out_ready) begin
        got32++;
        total++;
        if (q32.size() == 0) begin
          bad++; $display("FAIL rnd32_extra: got %h with nothing expected", {cout32, s32});
        end else begin
          e32 = q32.pop_front();
          eo  = qo32.pop_front();
          if ({cout32, s32} !== e32) begin bad++; $display("FAIL rnd32_data: got %h exp %h", {cout32, s32}, e32); end
`ifdef CLA_OVF_EN
          total++; if (ovf32 !== eo) begin bad++; $display("FAIL rnd32_ovf: got %b exp %b", ovf32, eo); end
`endif
        end
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (got < n || got32 < n) begin
      bad++; $display("FAIL rnd_timeout: got %0d/%0d beats exp %0d", got, got32, n);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_add_wrap;
    test_sub;
`ifdef CLA_OVF_EN
    test_ovf;
`endif
    test_backpressure;
    test_reset_midop;
    test_random(10000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
